// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD issue controller: opcodes, FSM state
// encoding, default geometry and small opcode classification helpers.
package simd_pkg;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 5;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_BITREV = 3'd3;
  localparam logic [2:0] OP_MUL    = 3'd4;
  localparam logic [2:0] OP_LOAD   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // ALU ops go through the register read and execute phases
  function automatic logic op_is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BITREV) || (op == OP_MUL);
  endfunction

  // Opcodes 6 and 7 are not defined and retire with an error pulse
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op > OP_LOAD;
  endfunction

endpackage

// File: rtl/simd_wb_mux.sv
// Per-lane write-back selection: either the captured ALU result of each
// lane or the LOAD immediate replicated to every lane. Data and enables are
// only driven during the write-back cycle.
module simd_wb_mux #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16
) (
  input  logic                          wb_i,
  input  logic                          is_load_i,
  input  logic [DATA_W-1:0]             imm_i,
  input  logic [NUM_LANES*DATA_W-1:0]   res_i,
  input  logic [NUM_LANES-1:0]          mask_i,
  output logic [NUM_LANES*DATA_W-1:0]   wr_data_o,
  output logic [NUM_LANES-1:0]          wr_en_o
);

  // Select per-lane write data; masked-off lanes still carry the value
  always_comb begin
    wr_data_o = '0;
    wr_en_o   = '0;
    if (wb_i) begin
      wr_en_o = mask_i;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_data_o[i*DATA_W +: DATA_W] = is_load_i ? imm_i : res_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/simd_issue_ctrl.sv
// Single-issue sequencer for the SIMD lane array. Accepts one instruction
// over valid/ready, steps it through RD -> EX -> WB -> DONE, drives shared
// lane addresses and one-hot ALU enables, and writes results back per lane.
// Optional performance counters are built when SIMD_ISSUE_PERF_EN is defined.
module simd_issue_ctrl
  import simd_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int READ_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [ADDR_W-1:0]             in_rs1,
  input  logic [ADDR_W-1:0]             in_rs2,
  input  logic [ADDR_W-1:0]             in_rd,
  input  logic [DATA_W-1:0]             in_imm,
  input  logic [NUM_LANES-1:0]          in_mask,
  output logic [ADDR_W-1:0]             rs1,
  output logic [ADDR_W-1:0]             rs2,
  output logic [ADDR_W-1:0]             rd,
  output logic                          rs1_rd_en,
  output logic                          rs2_rd_en,
  output logic                          Radd_en,
  output logic                          Rsub_en,
  output logic                          bitrev_en,
  output logic                          mul_en,
  input  logic [NUM_LANES*DATA_W-1:0]   alu_result,
  output logic [NUM_LANES*DATA_W-1:0]   wr_data,
  output logic [NUM_LANES-1:0]          rd_wr_en,
  output logic                          done,
  output logic                          err
`ifdef SIMD_ISSUE_PERF_EN
  ,
  input  logic                          cnt_clr,
  output logic [31:0]                   retired_cnt,
  output logic [31:0]                   busy_cycles
`endif
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [2:0]                    op_q;
  logic [ADDR_W-1:0]             rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0]             imm_q;
  logic [NUM_LANES-1:0]          mask_q;
  logic [NUM_LANES*DATA_W-1:0]   res_q;
  logic                          accept;
  logic                          rd_phase;
  logic                          busy;

  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign rd_phase = (state_q == ST_RD) || (state_q == ST_EX);

  // FSM state and read-latency counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; RD is held READ_LAT cycles before execute
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (op_is_alu(in_op))     state_d = ST_RD;
          else if (in_op == OP_LOAD) state_d = ST_WB;
          else                       state_d = ST_DONE;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) state_d = ST_EX;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_EX:   state_d = ST_WB;
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the instruction fields on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_NOP;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      op_q   <= in_op;
      rs1_q  <= in_rs1;
      rs2_q  <= in_rs2;
      rd_q   <= in_rd;
      imm_q  <= in_imm;
      mask_q <= in_mask;
    end
  end

  // Capture every lane's ALU result at the end of the execute cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
    end else if (state_q == ST_EX) begin
      res_q <= alu_result;
    end
  end

  // Lane control outputs decoded from state and latched opcode
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    rs1       = busy ? rs1_q : '0;
    rs2       = busy ? rs2_q : '0;
    rd        = busy ? rd_q  : '0;
    rs1_rd_en = rd_phase;
    rs2_rd_en = rd_phase;
    Radd_en   = rd_phase && (op_q == OP_ADD);
    Rsub_en   = rd_phase && (op_q == OP_SUB);
    bitrev_en = rd_phase && (op_q == OP_BITREV);
    mul_en    = rd_phase && (op_q == OP_MUL);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_DONE) && op_is_illegal(op_q);
  end

  simd_wb_mux #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W)
  ) u_wb_mux (
    .wb_i      (state_q == ST_WB),
    .is_load_i (op_q == OP_LOAD),
    .imm_i     (imm_q),
    .res_i     (res_q),
    .mask_i    (mask_q),
    .wr_data_o (wr_data),
    .wr_en_o   (rd_wr_en)
  );

`ifdef SIMD_ISSUE_PERF_EN
  logic [31:0] retired_q, busy_cyc_q;

  // Retire and busy-cycle counters; clear wins over increment, both wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q  <= '0;
      busy_cyc_q <= '0;
    end else if (cnt_clr) begin
      retired_q  <= '0;
      busy_cyc_q <= '0;
    end else begin
      if (done) retired_q  <= retired_q + 32'd1;
      if (busy) busy_cyc_q <= busy_cyc_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign busy_cycles = busy_cyc_q;
`endif

endmodule

// File: doc/simd_issue_ctrl.md
Name: simd_issue_ctrl

Overview:
- Single-issue sequencer for the 4-lane SIMD array. Each lane is a register file feeding an ALU with add, subtract, bit-reverse and multiply enables.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives shared rs1/rs2/rd addresses, read enables and one-hot op enables to all lanes.
- Captures every lane's ALU result and writes it back per lane under a lane mask, then pulses done.

Parameters:
- NUM_LANES, 4, number of SIMD lanes driven
- DATA_W, 16, lane data width
- ADDR_W, 5, register address width (32 registers)
- READ_LAT, 1, register-file read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction valid
- in_ready  out  1  controller can accept an instruction
- in_op  in  3  0 NOP, 1 ADD, 2 SUB, 3 BITREV, 4 MUL, 5 LOAD, 6-7 illegal
- in_rs1, in_rs2, in_rd  in  ADDR_W each  register addresses
- in_imm  in  DATA_W  immediate for LOAD
- in_mask  in  NUM_LANES  lane write mask
- rs1, rs2, rd  out  ADDR_W each  shared lane addresses
- rs1_rd_en, rs2_rd_en  out  1  lane read enables
- Radd_en, Rsub_en, bitrev_en, mul_en  out  1  one-hot ALU op enables
- alu_result  in  NUM_LANES*DATA_W  lane results; lane i at [i*DATA_W +: DATA_W]
- wr_data  out  NUM_LANES*DATA_W  per-lane write data
- rd_wr_en  out  NUM_LANES  per-lane write enable
- done  out  1  one-cycle retire pulse
- err  out  1  one-cycle illegal-opcode pulse

Behaviour:
- Reset while rst=0, asynchronous:
  - state IDLE, in_ready=1.
  - All other outputs 0; latched instruction fields 0.
- States: IDLE, RD, EX, WB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch op/rs1/rs2/rd/imm/mask and drop in_ready the next cycle.
  - Next state by op: ALU ops to RD; LOAD to WB; NOP to DONE; illegal to DONE with err=1 in the DONE cycle.
- RD:
  - rs1/rs2/rd driven from latched fields and held stable until IDLE.
  - rs1_rd_en=rs2_rd_en=1.
  - Matching op enable asserted, exactly one.
  - Stay READ_LAT cycles (counter), then go to EX.
- EX:
  - Read enables and op enable still held.
  - Sample alu_result into the result register at end of cycle.
  - Next state WB.
- WB, one cycle:
  - wr_data = captured results, or in_imm replicated to all lanes for LOAD.
  - rd_wr_en = latched mask.
  - All read and op enables 0.
  - Next state DONE.
- DONE, one cycle:
  - done=1, rd_wr_en=0.
  - Next state IDLE; in_ready=1 in the following cycle.
- Latency from accept edge to done:
  - ALU op: READ_LAT+3 cycles.
  - LOAD: 2 cycles.
  - NOP or illegal: 1 cycle.
- Mask rules:
  - mask=0: the WB cycle still occurs with no writes; done still pulses.
  - Masked-off lanes drive wr_data with the captured value; they are don't-care to the lanes.
- in_valid while busy is ignored (in_ready=0). The source must hold the instruction until accepted.
- rd may equal rs1 or rs2. Reads complete before WB, so there is no hazard.
- Reset asserted mid-instruction: immediate return to IDLE, no write issued, no done.
- Op enables are never asserted outside RD/EX. rd_wr_en is never asserted outside WB.

Optional Feature:
- Macro SIMD_ISSUE_PERF_EN.
- Defined:
  - Adds outputs retired_cnt (32 bits, +1 on each done) and busy_cycles (32 bits, +1 each cycle state≠IDLE).
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
  - Adds input cnt_clr, a synchronous clear that takes priority over increment.
- Undefined: these ports and registers are absent; all other behaviour identical.

Decomposition:
- Package simd_pkg holds:
  - Opcode constants OP_NOP..OP_LOAD.
  - State encoding typedef.
  - Default DATA_W/ADDR_W/NUM_LANES.
- Sub-module simd_wb_mux: per-lane wr_data/rd_wr_en selection between captured result and replicated immediate.
- FSM and counters stay in the top.

Test Plan:
- Issue ADD rs1=1 rs2=2 rd=3 mask=4'hF, lane results 16'h0005 each, READ_LAT=1:
  - Radd_en high for 2 cycles.
  - rd_wr_en=4'hF for 1 cycle with wr_data lanes =0005.
  - done 4 cycles after accept.
- LOAD imm=16'hBEEF rd=7 mask=4'b0101:
  - rd=7, rd_wr_en=4'b0101, all lanes =BEEF in one cycle.
  - done 2 cycles after accept.
  - No op enable ever asserted.
- Illegal op 6:
  - err and done pulse together 1 cycle after accept.
  - No read, op or write enables asserted.
- Back-to-back in_valid held high with SUB then MUL:
  - Second instruction accepted only after in_ready returns.
  - Rsub_en and mul_en never overlap.
- Assert rst in the EX state of a MUL:
  - All outputs 0 immediately, no rd_wr_en pulse.
  - in_ready=1 after release.
- With SIMD_ISSUE_PERF_EN: issue 3 instructions → retired_cnt=3. Then pulse cnt_clr → retired_cnt=0 and busy_cycles=0 next cycle.
